// File: rtl/forwarding_stall_unit.sv
`default_nettype none
// ============================================================================
// Module  : forwarding_stall_unit
// Brief   : EX operand forwarding selects plus load-use stall sequencer.
//           Optional macro ZERO_REG_EN hardwires register 0 to zero.
// Revision: 1.0 - initial release
// ============================================================================
module forwarding_stall_unit #(
    parameter int REG_ADDR_W = 3,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rs1,
    input  logic [REG_ADDR_W-1:0] ex_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_regwrite,
    input  logic                  ex_memread,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  mem_regwrite,
    input  logic                  wb_regwrite,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b,
    output logic                  stall_if,
    output logic                  flush_ex,
    output logic [CNT_W-1:0]      stall_count
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_STALL  = 1'b1;
    localparam logic [2:0] C_LAT_M1 = 3'(LOAD_LAT - 1);

    logic [0:0] r_state;
    logic [2:0] r_cnt;
    logic       w_mem_wr;
    logic       w_wb_wr;
    logic       w_ex_wr;
    logic       w_hz;

    // A write to r0 is invisible when r0 is hardwired zero.
`ifdef ZERO_REG_EN
    assign w_mem_wr = mem_regwrite && (mem_rd != '0);
    assign w_wb_wr  = wb_regwrite  && (wb_rd  != '0);
    assign w_ex_wr  = ex_regwrite  && (ex_rd  != '0);
`else
    assign w_mem_wr = mem_regwrite;
    assign w_wb_wr  = wb_regwrite;
    assign w_ex_wr  = ex_regwrite;
`endif

    always_comb begin
        forward_a = 2'b00;
        if (w_mem_wr && (mem_rd == ex_rs1))
            forward_a = 2'b10;
        else if (w_wb_wr && (wb_rd == ex_rs1))
            forward_a = 2'b01;
    end

    always_comb begin
        forward_b = 2'b00;
        if (w_mem_wr && (mem_rd == ex_rs2))
            forward_b = 2'b10;
        else if (w_wb_wr && (wb_rd == ex_rs2))
            forward_b = 2'b01;
    end

    assign w_hz = id_valid && w_ex_wr && ex_memread &&
                  ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    // First stall cycle is the detection cycle itself; STALL covers the rest.
    assign stall_if = (r_state == S_STALL) || w_hz;
    assign flush_ex = stall_if;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hz && (LOAD_LAT > 1)) begin
                        r_state <= S_STALL;
                        r_cnt   <= C_LAT_M1;
                    end
                end
                S_STALL: begin
                    r_cnt <= r_cnt - 3'd1;
                    if (r_cnt == 3'd1)
                        r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_count <= '0;
        else if (stall_if && (stall_count != {CNT_W{1'b1}}))
            stall_count <= stall_count + 1'b1;
    end

endmodule
`default_nettype wire

// File: tb/tb_forwarding_stall_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_forwarding_stall_unit
// Brief   : Directed bench for forwarding_stall_unit at LOAD_LAT 1 and 3.
// Revision: 1.0 - initial release
// ============================================================================
module tb_forwarding_stall_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [2:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic       ex_regwrite, ex_memread, mem_regwrite, wb_regwrite;

    logic [1:0]  fa1, fb1, fa3, fb3, fas, fbs;
    logic        st1, fl1, st3, fl3, sts, fls;
    logic [15:0] cnt1, cnt3;
    logic [1:0]  cnts;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    forwarding_stall_unit #(.REG_ADDR_W(3), .LOAD_LAT(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
        .forward_a(fa1), .forward_b(fb1), .stall_if(st1), .flush_ex(fl1),
        .stall_count(cnt1));

    forwarding_stall_unit #(.REG_ADDR_W(3), .LOAD_LAT(3), .CNT_W(16)) u_dut3 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
        .forward_a(fa3), .forward_b(fb3), .stall_if(st3), .flush_ex(fl3),
        .stall_count(cnt3));

    forwarding_stall_unit #(.REG_ADDR_W(3), .LOAD_LAT(1), .CNT_W(2)) u_dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
        .forward_a(fas), .forward_b(fbs), .stall_if(sts), .flush_ex(fls),
        .stall_count(cnts));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one edge, then let inputs settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; id_valid = 1'b0;
        id_rs1 = '0; id_rs2 = '0; ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0;
        mem_rd = '0; wb_rd = '0;
        ex_regwrite = 1'b0; ex_memread = 1'b0; mem_regwrite = 1'b0; wb_regwrite = 1'b0;
        tick(); tick();

        // Reset state; forwarding is live during reset
        mem_regwrite = 1'b1; mem_rd = 3'd2; ex_rs1 = 3'd2; #1;
        chk("rst_stall1", 32'(st1), 32'd0);
        chk("rst_flush3", 32'(fl3), 32'd0);
        chk("rst_cnt3", 32'(cnt3), 32'd0);
        chk("rst_fwd_a", 32'(fa1), 32'd2);
        mem_regwrite = 1'b0;
        rst = 1'b0;
        tick();

        // Forward priority
        ex_rs1 = 3'd3; ex_rs2 = 3'd4;
        mem_rd = 3'd3; mem_regwrite = 1'b1; wb_rd = 3'd3; wb_regwrite = 1'b1; #1;
        chk("fwd_a_mem_prio", 32'(fa1), 32'd2);
        chk("fwd_b_none", 32'(fb1), 32'd0);
        mem_regwrite = 1'b0; ex_rs2 = 3'd3; #1;
        chk("fwd_a_wb", 32'(fa1), 32'd1);
        chk("fwd_b_wb", 32'(fb3), 32'd1);
        wb_regwrite = 1'b0; #1;
        chk("fwd_b_off", 32'(fb1), 32'd0);

        // Load-use hazard at cycle T
        id_valid = 1'b1; ex_regwrite = 1'b1; ex_memread = 1'b1;
        ex_rd = 3'd5; id_rs1 = 3'd1; id_rs2 = 3'd5; #1;
        chk("T_stall1", 32'(st1), 32'd1);
        chk("T_flush1", 32'(fl1), 32'd1);
        chk("T_stall3", 32'(st3), 32'd1);
        tick();
        ex_memread = 1'b0; id_valid = 1'b0; #1;
        chk("T1_stall1", 32'(st1), 32'd0);
        chk("T1_cnt1", 32'(cnt1), 32'd1);
        chk("T1_stall3", 32'(st3), 32'd1);
        chk("T1_flush3", 32'(fl3), 32'd1);
        tick();
        chk("T2_stall3", 32'(st3), 32'd1);
        chk("T2_cnt3", 32'(cnt3), 32'd2);
        tick();
        chk("T3_stall3", 32'(st3), 32'd0);
        chk("T3_cnt3", 32'(cnt3), 32'd3);
        chk("T3_cnt1", 32'(cnt1), 32'd1);

        // id_valid low masks the hazard
        ex_memread = 1'b1; #1;
        chk("novalid_stall1", 32'(st1), 32'd0);
        chk("novalid_stall3", 32'(st3), 32'd0);
        ex_memread = 1'b0; id_rs2 = 3'd6; id_valid = 1'b1; ex_memread = 1'b1; #1;
        chk("nomatch_stall1", 32'(st1), 32'd0);
        ex_memread = 1'b0; id_rs2 = 3'd5;

        // Reset mid-stall
        tick();
        ex_memread = 1'b1; #1;
        chk("R_T_stall3", 32'(st3), 32'd1);
        tick();
        ex_memread = 1'b0; rst = 1'b1; #1;
        chk("R_T1_stall3", 32'(st3), 32'd1);
        tick();
        rst = 1'b0; #1;
        chk("R_T2_stall3", 32'(st3), 32'd0);
        chk("R_T2_cnt3", 32'(cnt3), 32'd0);
        tick();
        chk("R_T3_stall3", 32'(st3), 32'd0);

        // Continuous hazard: saturation and re-triggering
        ex_memread = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("sat_cnt_3", 32'(cnts), 32'd3);
        for (int i = 0; i < 2; i++) tick();
        chk("sat_cnt_hold", 32'(cnts), 32'd3);
        chk("cnt1_five", 32'(cnt1), 32'd5);
        chk("cnt3_five", 32'(cnt3), 32'd5);
        ex_memread = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("drain_stall3", 32'(st3), 32'd0);

        // Register 0 behaviour
        ex_rd = 3'd0; id_rs1 = 3'd0; id_rs2 = 3'd7; ex_memread = 1'b1;
        mem_rd = 3'd0; mem_regwrite = 1'b1; ex_rs1 = 3'd0; #1;
`ifdef ZERO_REG_EN
        chk("r0_stall1", 32'(st1), 32'd0);
        chk("r0_fwd_a", 32'(fa1), 32'd0);
`else
        chk("r0_stall1", 32'(st1), 32'd1);
        chk("r0_fwd_a", 32'(fa1), 32'd2);
`endif
        ex_memread = 1'b0; mem_regwrite = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
